// File: rtl/mire_pkg.sv
// Shared types and constants for the test-pattern framebuffer writer.
package mire_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [23:0] GRID_COLOR = 24'hFFFFFF;
  localparam logic [3:0]  GRID_MASK  = 4'hF;

endpackage

// File: rtl/wshb_if.sv
// Minimal Wishbone bundle: one clock, async active-high reset, write-only master.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    input  clk, rst, ack,
    output cyc, stb, we, sel, adr, dat_ms, cti, bte
  );
endinterface

// File: rtl/mire_pattern.sv
// Combinational pixel generator: white grid every 16 pixels, gradient elsewhere.
module mire_pattern
  import mire_pkg::*;
(
  input  logic [7:0]  i_x,
  input  logic [7:0]  i_y,
  input  logic [7:0]  i_frame_cnt,
  output logic [31:0] o_data
);

  logic w_grid;

  // Pick grid colour on every 16th column/row, otherwise animate red by frame.
  always_comb begin
    w_grid = ((i_x[3:0] & GRID_MASK) == 4'h0) || ((i_y[3:0] & GRID_MASK) == 4'h0);
    if (w_grid) o_data = {8'h00, GRID_COLOR};
    else        o_data = {8'h00, i_x + i_frame_cnt, i_y, i_frame_cnt};
  end

endmodule

// File: rtl/mire_writer.sv
// Wishbone master filling the framebuffer with the test pattern in fixed bursts.
module mire_writer
  import mire_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BURST = 64
) (
  wshb_if.master     wshb_ifm,
  input  logic       enable,
  output logic [7:0] frame_cnt,
  output logic       frame_done
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int BW = $clog2(BURST + 1);

  state_t         r_state, w_next;
  logic [XW-1:0]  r_x, w_x_nxt;
  logic [YW-1:0]  r_y, w_y_nxt;
  logic [BW-1:0]  r_burst;
  logic [7:0]     r_frame_cnt, w_fc_nxt;
  logic           r_frame_done;
  logic [31:0]    r_adr, r_dat, w_adr_nxt, w_pix;
  logic           w_ack, w_x_last, w_y_last, w_frame_last, w_burst_last;

  // stb is derived from the state, so an ack outside WRITE is simply ignored.
  assign w_ack        = (r_state == WRITE) && wshb_ifm.ack;
  assign w_x_last     = (r_x == XW'(HDISP - 1));
  assign w_y_last     = (r_y == YW'(VDISP - 1));
  assign w_frame_last = w_x_last && w_y_last;
  assign w_burst_last = (r_burst == BW'(BURST - 1));

  // Position following the one being written; adr/dat are registered from it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_x_nxt  = r_x + XW'(1);
    w_y_nxt  = r_y;
    w_fc_nxt = r_frame_cnt;
    if (w_x_last) begin
      w_x_nxt = '0;
      if (w_y_last) begin
        w_y_nxt  = '0;
        w_fc_nxt = r_frame_cnt + 8'd1;
      end else begin
        w_y_nxt = r_y + YW'(1);
      end
    end
    w_adr_nxt = (32'(w_y_nxt) * 32'(HDISP) + 32'(w_x_nxt)) << 2;
  end

  mire_pattern u_pattern (
    .i_x         (8'(w_x_nxt)),
    .i_y         (8'(w_y_nxt)),
    .i_frame_cnt (w_fc_nxt),
    .o_data      (w_pix)
  );

  // State register.
  always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (wshb_ifm.rst) r_state <= IDLE;
    else              r_state <= w_next;
  end

  // Next-state: bursts end in a one-cycle PAUSE; a dropped enable ends after the ack.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (enable) w_next = WRITE;
      WRITE: if (w_ack) begin
               if (w_burst_last || w_frame_last) w_next = PAUSE;
               else if (!enable)                 w_next = IDLE;
             end
      PAUSE: w_next = enable ? WRITE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus outputs: only cyc/stb depend on state, the rest are constant or registered.
  always_comb begin
    wshb_ifm.cyc    = (r_state == WRITE);
    wshb_ifm.stb    = (r_state == WRITE);
    wshb_ifm.we     = 1'b1;
    wshb_ifm.sel    = 4'b1111;
    wshb_ifm.cti    = 3'b000;
    wshb_ifm.bte    = 2'b00;
    wshb_ifm.adr    = r_adr;
    wshb_ifm.dat_ms = r_dat;
  end

  // Position, frame counter and registered pixel word advance on each accepted write.
  always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
    if (wshb_ifm.rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
      r_adr        <= '0;
      r_dat        <= {8'h00, GRID_COLOR};
    end else begin
      r_frame_done <= w_ack && w_frame_last;
      if (w_ack) begin
        r_x         <= w_x_nxt;
        r_y         <= w_y_nxt;
        r_frame_cnt <= w_fc_nxt;
        r_adr       <= w_adr_nxt;
        r_dat       <= w_pix;
      end
    end
  end

  // Burst counter: counts acks inside WRITE, cleared in IDLE and PAUSE.
  always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
    if (wshb_ifm.rst)            r_burst <= '0;
    else if (r_state != WRITE)   r_burst <= '0;
    else if (w_ack)              r_burst <= r_burst + BW'(1);
  end

  assign frame_cnt  = r_frame_cnt;
  assign frame_done = r_frame_done;

endmodule
